// File: rtl/spi_cmd_receiver_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_receiver_pkg
// Shared definitions for the SPI command receiver: default word length,
// bit-counter width and the controller FSM state encoding.
// -----------------------------------------------------------------------------
package spi_cmd_receiver_pkg;

   // Default command/response word length in bits.
   localparam int unsigned WORD_WIDTH_DEF = 32;

   // Bit counter width; must hold WORD_WIDTH+1 without wrapping.
   localparam int unsigned CNT_W = 6;

   // Receiver controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } rx_state_t;

endpackage : spi_cmd_receiver_pkg

// File: rtl/spi_input_sync.sv
// -----------------------------------------------------------------------------
// spi_input_sync
// Multi-flop synchronizer with edge detection for one asynchronous pin.
//
// Ports:
//   clock     in  system clock (rising edge)
//   reset     in  synchronous active-high reset, loads RESET_LEVEL everywhere
//   async_in  in  asynchronous pin
//   sync_out  out synchronized level (last synchronizer stage)
//   rise      out synchronized level went 0 -> 1
//   fall      out synchronized level went 1 -> 0
//
// Edges are reported only once both compared samples originate from the pin
// rather than from the reset load, so a pin already sitting at the opposite
// level when reset releases does not look like a fresh edge.
// -----------------------------------------------------------------------------
module spi_input_sync #(
   parameter int unsigned STAGES      = 2,
   parameter logic        RESET_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;
   logic [STAGES:0]   fill_r;
   logic              primed_s;

   // Synchronizer chain, previous-sample flop and fill tracker.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_r <= {STAGES{RESET_LEVEL}};
         prev_r <= RESET_LEVEL;
         fill_r <= {(STAGES + 1){1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], async_in};
         prev_r <= sync_r[STAGES-1];
         fill_r <= {fill_r[STAGES-1:0], 1'b1};
      end
   end

   // prev_r holds a real pin sample once STAGES+1 clocks have passed.
   assign primed_s = fill_r[STAGES];
   assign sync_out = sync_r[STAGES-1];
   assign rise     = primed_s &  sync_r[STAGES-1] & ~prev_r;
   assign fall     = primed_s & ~sync_r[STAGES-1] &  prev_r;

endmodule : spi_input_sync

// File: rtl/spi_cmd_receiver.sv
// -----------------------------------------------------------------------------
// spi_cmd_receiver
// SPI mode-0 slave that receives one WORD_WIDTH command word per ss_n frame
// and returns a response word captured at frame start.
//
// Ports:
//   clock        in  system clock (>= 4x sclk)
//   reset        in  synchronous active-high reset
//   sclk         in  SPI clock, asynchronous, CPOL=0/CPHA=0
//   mosi         in  SPI data in, MSB first
//   ss_n         in  SPI select, active low
//   miso         out SPI data out, MSB first, 0 outside a frame
//   resp_data    in  response word, loaded at frame start
//   cmd_data     out last correctly sized command word
//   cmd_valid    out one-cycle pulse when cmd_data updates
//   frame_error  out one-cycle pulse when a frame had the wrong bit count
//   busy         out high while a frame is being shifted or checked
// -----------------------------------------------------------------------------
module spi_cmd_receiver
   import spi_cmd_receiver_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = WORD_WIDTH_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  ss_n,
   output logic                  miso,
   input  logic [WORD_WIDTH-1:0] resp_data,
   output logic [WORD_WIDTH-1:0] cmd_data,
   output logic                  cmd_valid,
   output logic                  frame_error,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Synchronized pins and edges
   logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
   logic mosi_sync_s, mosi_rise_s, mosi_fall_s;
   logic ss_sync_s, ss_rise_s, ss_fall_s;
   logic unused_sync_s;

   // Controller
   rx_state_t state_r, state_next_s;
   logic      frame_start_s, rx_shift_s, tx_shift_s, cmd_load_s, err_s;

   // Datapath
   logic [WORD_WIDTH-1:0] tx_r, tx_next_s, rx_r, cmd_data_r;
   logic [CNT_W-1:0]      bit_cnt_r;
   logic                  cmd_valid_r, frame_error_r, busy_r, miso_r;

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
      .clock(clock), .reset(reset), .async_in(sclk),
      .sync_out(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
      .clock(clock), .reset(reset), .async_in(mosi),
      .sync_out(mosi_sync_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_ss (
      .clock(clock), .reset(reset), .async_in(ss_n),
      .sync_out(ss_sync_s), .rise(ss_rise_s), .fall(ss_fall_s)
   );

   assign unused_sync_s = ^{sclk_sync_s, mosi_rise_s, mosi_fall_s, ss_sync_s};

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; a select falling edge in CHECK is deliberately dropped.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ss_fall_s) state_next_s = ST_SHIFT;
            else           state_next_s = ST_IDLE;
         end
         ST_SHIFT: begin
            if (ss_rise_s) state_next_s = ST_CHECK;
            else           state_next_s = ST_SHIFT;
         end
         ST_CHECK: state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // FSM output decode; sclk edges coinciding with the closing select edge are ignored.
   always_comb begin
      frame_start_s = 1'b0;
      rx_shift_s    = 1'b0;
      tx_shift_s    = 1'b0;
      cmd_load_s    = 1'b0;
      err_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            frame_start_s = ss_fall_s;
         end
         ST_SHIFT: begin
            rx_shift_s = sclk_rise_s & ~ss_rise_s;
            tx_shift_s = sclk_fall_s & ~ss_rise_s;
         end
         ST_CHECK: begin
            if (bit_cnt_r == CNT_FULL) cmd_load_s = 1'b1;
            else                       err_s      = 1'b1;
         end
         default: begin
            frame_start_s = 1'b0;
            rx_shift_s    = 1'b0;
            tx_shift_s    = 1'b0;
            cmd_load_s    = 1'b0;
            err_s         = 1'b0;
         end
      endcase
   end

   // Next value of the transmit shifter, shared by the shifter and the miso register.
   always_comb begin
      if (frame_start_s) begin
         tx_next_s = resp_data;
      end else if (tx_shift_s) begin
         tx_next_s = {tx_r[WORD_WIDTH-2:0], 1'b0};
      end else begin
         tx_next_s = tx_r;
      end
   end

   // Shifters, bit counter and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_r          <= {WORD_WIDTH{1'b0}};
         rx_r          <= {WORD_WIDTH{1'b0}};
         bit_cnt_r     <= {CNT_W{1'b0}};
         cmd_data_r    <= {WORD_WIDTH{1'b0}};
         cmd_valid_r   <= 1'b0;
         frame_error_r <= 1'b0;
         busy_r        <= 1'b0;
         miso_r        <= 1'b0;
      end else begin
         tx_r <= tx_next_s;
         if (frame_start_s) begin
            rx_r      <= {WORD_WIDTH{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
         end else if (rx_shift_s) begin
            rx_r <= {rx_r[WORD_WIDTH-2:0], mosi_sync_s};
            // Saturate so that very long frames never wrap back to a valid count.
            if (bit_cnt_r != CNT_SAT) begin
               bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
         end
         if (cmd_load_s) begin
            cmd_data_r <= rx_r;
         end
         cmd_valid_r   <= cmd_load_s;
         frame_error_r <= err_s;
         // Registered from next-state so busy/miso line up with the state register.
         busy_r        <= (state_next_s != ST_IDLE);
         miso_r        <= (state_next_s == ST_SHIFT) ? tx_next_s[WORD_WIDTH-1] : 1'b0;
      end
   end

   assign cmd_data    = cmd_data_r;
   assign cmd_valid   = cmd_valid_r;
   assign frame_error = frame_error_r;
   assign busy        = busy_r;
   assign miso        = miso_r;

endmodule : spi_cmd_receiver

// File: tb/tb_spi_cmd_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_receiver
// Directed SPI frames; expected cmd_valid/frame_error events are queued when
// ss_n closes a frame and a monitor pops and compares them as pulses appear.
// -----------------------------------------------------------------------------
module tb_spi_cmd_receiver;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          sclk;
   logic          mosi;
   logic          ss_n;
   logic          miso;
   logic [W-1:0]  resp_data;
   logic [W-1:0]  cmd_data;
   logic          cmd_valid;
   logic          frame_error;
   logic          busy;

   spi_cmd_receiver #(.WORD_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
      .miso(miso), .resp_data(resp_data), .cmd_data(cmd_data),
      .cmd_valid(cmd_valid), .frame_error(frame_error), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      logic [31:0] data;
      int          exp_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   logic [31:0] model_cmd = 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Monitor: scoreboard pop/compare on every output pulse.
   always @(negedge clock) begin
      exp_t e;
      if (mon_en) begin
         check("no_x_outputs", 64'($isunknown({miso, cmd_data, cmd_valid, frame_error, busy})), 64'd0);
         if (cmd_valid && frame_error) begin
            check("pulses_exclusive", 64'd1, 64'd0);
         end else if (cmd_valid || frame_error) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse: cmd_valid=%0b frame_error=%0b, expected none (cycle %0d)",
                        cmd_valid, frame_error, cyc);
            end else begin
               e = sb_q.pop_front();
               check("pulse_kind_err", 64'(frame_error), 64'(e.is_err));
               check("pulse_cycle", 64'(cyc), 64'(e.exp_cyc));
               check("cmd_data", 64'(cmd_data), 64'(e.data));
            end
         end
         if (sb_q.size() > 0 && cyc > sb_q[0].exp_cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: no pulse observed, expected is_err=%0b by cycle %0d", e.is_err, e.exp_cyc);
         end
      end
   end

   // One frame: exp_kind 0 = cmd_valid, 1 = frame_error, 2 = no pulse.
   task automatic send_frame(input logic [127:0] bits, input int nbits, input int half,
                             input bit chk_miso, input logic [31:0] exp_miso,
                             input bit glitch, input int exp_kind, input int gap);
      logic [31:0] mcap;
      mcap = 32'h0;
      ss_n = 1'b0;
      wait_clks(half);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = bits[i];
         wait_clks(half);
         if ((nbits - 1 - i) < 32) mcap = {mcap[30:0], miso};
         sclk = 1'b1;
         wait_clks(1);
         mosi = ~mosi;               // data changes shortly after the sampling edge
         wait_clks(half - 1);
         sclk = 1'b0;
      end
      wait_clks(half);
      check("busy_in_frame", 64'(busy), 64'd1);
      if (glitch) sclk = 1'b1;       // extra sclk edge simultaneous with ss_n rising
      ss_n = 1'b1;
      if (exp_kind == 0) begin
         model_cmd = bits[31:0];
         sb_q.push_back('{is_err: 1'b0, data: model_cmd, exp_cyc: cyc + 4});
      end else if (exp_kind == 1) begin
         sb_q.push_back('{is_err: 1'b1, data: model_cmd, exp_cyc: cyc + 4});
      end
      wait_clks(1);
      sclk = 1'b0;
      mosi = 1'b0;
      wait_clks(gap - 1);
      if (gap >= 6) begin
         check("busy_idle", 64'(busy), 64'd0);
         check("miso_idle", 64'(miso), 64'd0);
      end
      if (chk_miso) check("miso_stream", 64'(mcap), 64'(exp_miso));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; resp_data = 32'h0;
      wait_clks(3);
      check("rst_cmd_data", 64'(cmd_data), 64'd0);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_frame_error", 64'(frame_error), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_miso", 64'(miso), 64'd0);
      reset = 1'b0;
      mon_en = 1'b1;
      wait_clks(6);

      // Nominal 32-bit frame with response readback.
      resp_data = 32'h1234_5678;
      send_frame(128'hA5C3_0F81, 32, 4, 1'b1, 32'h1234_5678, 1'b0, 0, 10);
      // Short and long frames keep cmd_data.
      send_frame(128'h1234_5678, 31, 4, 1'b0, 32'h0, 1'b0, 1, 10);
      send_frame(128'h1_2345_6789, 33, 4, 1'b0, 32'h0, 1'b0, 1, 10);
      // 96 bits: a wrapping 6-bit counter would read 32 here.
      send_frame(128'hDEAD_BEEF_0123_4567_89AB_CDEF, 96, 4, 1'b0, 32'h0, 1'b0, 1, 10);
      // sclk edge together with ss_n rising is not counted.
      resp_data = 32'h8000_0001;
      send_frame(128'h5A5A_1234, 32, 4, 1'b1, 32'h8000_0001, 1'b1, 0, 10);

      // Reset in the middle of a frame, released with ss_n still low.
      ss_n = 1'b0;
      wait_clks(4);
      for (int i = 0; i < 16; i++) begin
         mosi = i[0];
         wait_clks(4);
         sclk = 1'b1;
         wait_clks(4);
         sclk = 1'b0;
      end
      reset = 1'b1;
      wait_clks(3);
      reset = 1'b0;
      model_cmd = 32'h0;
      check("abort_cmd_data", 64'(cmd_data), 64'd0);
      wait_clks(20);
      check("abort_busy", 64'(busy), 64'd0);
      ss_n = 1'b1;
      wait_clks(10);
      resp_data = 32'hCAFE_F00D;
      send_frame(128'h0000_0001, 32, 4, 1'b1, 32'hCAFE_F00D, 1'b0, 0, 10);

      // Back-to-back frames with a 2-clock ss_n high gap.
      resp_data = 32'h0F0F_F0F0;
      send_frame(128'hFFFF_FFFF, 32, 4, 1'b1, 32'h0F0F_F0F0, 1'b0, 0, 2);
      resp_data = 32'hAAAA_5555;
      send_frame(128'h0000_0000, 32, 4, 1'b1, 32'hAAAA_5555, 1'b0, 0, 10);

      // sclk at clock/4 with mosi moving right after each rising edge.
      send_frame(128'h3C96_E1A7, 32, 2, 1'b0, 32'h0, 1'b0, 0, 10);

      wait_clks(20);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_spi_cmd_receiver

// File: doc/spi_cmd_receiver.md
SPI_CMD_RECEIVER -- requirements
Module: spi_cmd_receiver

Interface
REQ-001 Parameter WORD_WIDTH, default 32, command/response word length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk/mosi/ss_n.
REQ-003 clock  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sclk  in  1  SPI serial clock, asynchronous to clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 mosi  in  1  SPI data in, MSB first.
REQ-007 ss_n  in  1  SPI select, active low, frames one transfer.
REQ-008 miso  out  1  SPI data out, MSB first.
REQ-009 resp_data  in  WORD_WIDTH  response word, sampled at frame start.
REQ-010 cmd_data  out  WORD_WIDTH  last good command word, held until next good frame.
REQ-011 cmd_valid  out  1  one-cycle pulse when cmd_data updates.
REQ-012 frame_error  out  1  one-cycle pulse on a malformed frame.
REQ-013 busy  out  1  high while a frame is in progress.

Function
REQ-014 sclk, mosi and ss_n SHALL each pass through SYNC_STAGES flops before any use; edges SHALL be detected from the last two synchronized samples.
REQ-015 The FSM SHALL have states IDLE, SHIFT, CHECK; reset state IDLE.
REQ-016 IDLE -> SHIFT on synchronized ss_n falling edge; resp_data SHALL be loaded into the transmit shifter, the bit counter cleared, and the receive shifter cleared.
REQ-017 In SHIFT, each synchronized sclk rising edge SHALL shift mosi into the receive shifter LSB and increment the 6-bit bit counter, saturating at WORD_WIDTH+1.
REQ-018 In SHIFT, each synchronized sclk falling edge SHALL shift the transmit shifter left by one; miso SHALL equal the transmit shifter MSB.
REQ-019 SHIFT -> CHECK on synchronized ss_n rising edge; an sclk edge detected in the same cycle SHALL be ignored.
REQ-020 In CHECK, when the bit count equals WORD_WIDTH exactly, cmd_data SHALL load the receive shifter and cmd_valid SHALL pulse for one cycle; otherwise frame_error SHALL pulse for one cycle and cmd_data SHALL remain unchanged. CHECK -> IDLE unconditionally.
REQ-021 cmd_valid and frame_error SHALL never be high in the same cycle.
REQ-022 busy SHALL be high in SHIFT and CHECK and low in IDLE.
REQ-023 Outside SHIFT, miso SHALL be 0.
REQ-024 Latency: cmd_valid SHALL assert exactly 2 clock cycles after the cycle in which the synchronized ss_n rising edge is detected.
REQ-025 An ss_n falling edge detected in CHECK SHALL be ignored; the next frame SHALL start only from IDLE.
REQ-026 The clock SHALL be at least 4x sclk frequency; behaviour below this ratio is undefined.

Reset
REQ-027 Reset SHALL force: state IDLE, all synchronizer flops to idle levels (sclk 0, mosi 0, ss_n 1), cmd_data 0, cmd_valid 0, frame_error 0, busy 0, miso 0, shifters and counter 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without cmd_valid or frame_error; after release the block SHALL wait in IDLE for a fresh ss_n falling edge, even if ss_n is already low.

Structure
REQ-029 The FSM state encoding and the WORD_WIDTH default SHALL reside in the shared controller package.
REQ-030 One sub-module, spi_input_sync (parameterized depth and reset level, edge-detect outputs), SHALL be instantiated three times; all other logic SHALL be flat.
REQ-031 cmd_data and cmd_valid SHALL be registered outputs that drive the system controller command/latch inputs directly.

Verification
REQ-032 Send 0xA5C3_0F81 in a 32-bit frame with resp_data=0x1234_5678 -> cmd_data=0xA5C30F81, one cmd_valid pulse; miso bit stream equals 0x12345678.
REQ-033 Send a 31-bit frame -> frame_error pulses once; cmd_data keeps its prior value; no cmd_valid.
REQ-034 Send a 33-bit frame -> frame_error pulses once; the counter saturates and does not wrap.
REQ-035 Assert reset at bit 16 of a frame, then release it with ss_n still low -> no pulses; the next full frame 0x0000_0001 decodes correctly.
REQ-036 Two back-to-back frames 0xFFFF_FFFF and 0x0000_0000 with a 2-clock ss_n high gap -> two cmd_valid pulses with the correct words in order.
REQ-037 Drive sclk at clock/4 with mosi toggling near the sclk edges -> no metastability propagation (X checks); data matches the sclk-rising samples.
